// File: rtl/muldiv_pkg.sv
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared constants and state encoding for the RV32M unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } md_state_t;

  localparam logic [31:0] DIV0_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] OVF_Q  = 32'h8000_0000;

  localparam int MD_ITER = 32;

  // rs1 is treated as signed by MULH, MULHSU, DIV and REM
  function automatic logic src1_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic src2_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

`default_nettype wire

// File: rtl/e_muldiv_unit_if.sv
// ============================================================================
// Module      : e_muldiv_unit_if
// Description : Request/response bundle between the E stage and the M unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface e_muldiv_unit_if #(
  parameter int XLEN = 32
);

  logic            flush;
  logic            start;
  logic [2:0]      func3;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic [4:0]      rd_index;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_index_out;

  modport master (
    output flush, start, func3, src1, src2, rd_index,
    input  stall, done, result, rd_index_out
  );

  modport slave (
    input  flush, start, func3, src1, src2, rd_index,
    output stall, done, result, rd_index_out
  );

endinterface

`default_nettype wire

// File: rtl/muldiv_step.sv
// ============================================================================
// Module      : muldiv_step
// Description : One combinational iteration of shift-add multiply and
//               restoring divide.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   mcand,
  output logic [2*XLEN-1:0] acc_next,
  input  logic [XLEN-1:0]   rem,
  input  logic [XLEN-1:0]   quot,
  input  logic [XLEN-1:0]   divisor,
  output logic [XLEN-1:0]   rem_next,
  output logic [XLEN-1:0]   quot_next
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  always_comb begin
    // Multiplier bits sit in the low half and are consumed LSB first
    sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand} : '0);
    acc_next = {sum, acc[XLEN-1:1]};

    shifted = {rem, quot[XLEN-1]};
    diff    = shifted - {1'b0, divisor};
    if (!diff[XLEN]) begin
      rem_next  = diff[XLEN-1:0];
      quot_next = {quot[XLEN-2:0], 1'b1};
    end else begin
      // Restored remainder is below the divisor, so its top bit is zero
      rem_next  = shifted[XLEN-1:0];
      quot_next = {quot[XLEN-2:0], 1'b0};
    end
  end

endmodule

`default_nettype wire

// File: rtl/e_muldiv_unit.sv
// ============================================================================
// Module      : e_muldiv_unit
// Description : Iterative RV32M multiply/divide unit in the execute stage.
//               Optional macro MULDIV_FAST_MUL_EN: single-cycle multiplies.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module e_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  e_muldiv_unit_if.slave   bus
);

  md_state_t state;
  md_state_t state_next;

  logic [CNT_W-1:0]  cnt;
  logic [2:0]        f3_q;
  logic [4:0]        rd_q;
  logic              neg_a;
  logic              neg_b;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opb;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   quot;
  logic [XLEN-1:0]   result_q;
  logic [4:0]        rd_out_q;
  logic              done_q;
  logic              stall_c;

  logic              is_div;
  logic              s1;
  logic              s2;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic              div_zero;
  logic              div_ovf;
  logic              special;
  logic [XLEN-1:0]   special_res;
  logic              fast_go;
  logic [XLEN-1:0]   fast_res;
  logic              last_iter;

  logic [2*XLEN-1:0] acc_next;
  logic [XLEN-1:0]   rem_next;
  logic [XLEN-1:0]   quot_next;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   calc_res;

  // Operand decode for the instruction sitting in E
  assign is_div   = bus.func3[2];
  assign s1       = src1_signed(bus.func3) & bus.src1[XLEN-1];
  assign s2       = src2_signed(bus.func3) & bus.src2[XLEN-1];
  assign mag_a    = s1 ? -bus.src1 : bus.src1;
  assign mag_b    = s2 ? -bus.src2 : bus.src2;
  assign div_zero = is_div && (bus.src2 == '0);
  assign div_ovf  = ((bus.func3 == F3_DIV) || (bus.func3 == F3_REM)) &&
                    (bus.src1 == OVF_Q) && (bus.src2 == '1);
  assign special  = div_zero | div_ovf;

  // func3[1] separates REM* from DIV*
  assign special_res = div_zero ? (bus.func3[1] ? bus.src1 : DIV0_Q)
                                : (bus.func3[1] ? '0       : OVF_Q);

`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*XLEN+1:0] fast_prod;
  assign fast_prod = $signed({s1, bus.src1}) * $signed({s2, bus.src2});
  assign fast_go   = ~is_div;
  assign fast_res  = (bus.func3 == F3_MUL) ? fast_prod[XLEN-1:0]
                                           : fast_prod[2*XLEN-1:XLEN];
`else
  assign fast_go  = 1'b0;
  assign fast_res = '0;
`endif

  assign last_iter = (cnt == CNT_W'(MD_ITER - 1));

  muldiv_step #(
    .XLEN (XLEN)
  ) u_step (
    .acc       (acc),
    .mcand     (opb),
    .acc_next  (acc_next),
    .rem       (rem),
    .quot      (quot),
    .divisor   (opb),
    .rem_next  (rem_next),
    .quot_next (quot_next)
  );

  // Sign fix and selection of the final iteration's outputs
  always_comb begin
    prod_fix = (neg_a ^ neg_b) ? -acc_next  : acc_next;
    quot_fix = (neg_a ^ neg_b) ? -quot_next : quot_next;
    rem_fix  = neg_a ? -rem_next : rem_next;
    case (f3_q)
      F3_MUL:                       calc_res = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: calc_res = prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              calc_res = quot_fix;
      default:                      calc_res = rem_fix;
    endcase
  end

  // State register
  always_ff @(negedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; flush overrides everything
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = (special || fast_go) ? DONE : CALC;
        end
      end
      CALC: begin
        if (last_iter) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (bus.flush) begin
      state_next = IDLE;
    end
  end

  // Output logic
  always_comb begin
    stall_c = ((state == IDLE) && bus.start && !bus.flush) || (state == CALC);
  end

  // Datapath registers
  always_ff @(negedge clk) begin
    if (!rst) begin
      cnt      <= '0;
      f3_q     <= '0;
      rd_q     <= '0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      acc      <= '0;
      opb      <= '0;
      rem      <= '0;
      quot     <= '0;
      result_q <= '0;
      rd_out_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && !bus.flush) begin
            f3_q  <= bus.func3;
            rd_q  <= bus.rd_index;
            neg_a <= s1;
            neg_b <= s2;
            cnt   <= '0;
            acc   <= {{XLEN{1'b0}}, mag_a};
            opb   <= mag_b;
            rem   <= '0;
            quot  <= mag_a;
            if (special || fast_go) begin
              result_q <= special ? special_res : fast_res;
              rd_out_q <= bus.rd_index;
              done_q   <= 1'b1;
            end
          end
        end
        CALC: begin
          if (!bus.flush) begin
            acc  <= acc_next;
            rem  <= rem_next;
            quot <= quot_next;
            cnt  <= cnt + CNT_W'(1);
            if (last_iter) begin
              result_q <= calc_res;
              rd_out_q <= rd_q;
              done_q   <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.stall        = stall_c;
  assign bus.done         = done_q;
  assign bus.result       = result_q;
  assign bus.rd_index_out = rd_out_q;

endmodule

`default_nettype wire

// File: doc/e_muldiv_unit.md
# e_muldiv_unit

Iterative RV32M multiply/divide unit in the execute stage, directly downstream of the D/E pipeline register. It consumes the registered operands, func3 and rd index of an M-extension instruction. It stalls the front of the pipeline while computing, then presents a 32-bit result to the E/M path for exactly one cycle. Plain ALU ops bypass it; it stays idle unless `start` is high.

## Interface
- `XLEN`, 32: operand/result width; only 32 is supported.
- `CNT_W`, 5: iteration counter width, log2(XLEN).

- `clk` in 1: pipeline clock; all state updates on the falling edge, matching the pipeline registers.
- `rst` in 1: reset, synchronous, active-low.
- `flush` in 1: branch/jump flush; aborts any operation.
- `start` in 1: the E-stage instruction is an M-op, decoded upstream from opcode and func7.
- `func3` in 3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `src1` in 32: rs1 operand, after forwarding.
- `src2` in 32: rs2 operand, after forwarding.
- `rd_index` in 5: destination register.
- `stall` out 1: freezes PC, F/D and D/E.
- `done` out 1: `result` is valid this cycle.
- `result` out 32: final value.
- `rd_index_out` out 5: latched destination.

## Operation
- FSM states: IDLE, CALC, DONE. Reset puts the FSM in IDLE and clears all outputs and internal registers to 0.
- IDLE:
  - `start` is sampled only in IDLE. On `start`, latch func3, rd_index, operand magnitudes and sign flags.
  - Divide by zero (src2==0):
    - Quotient = 0xFFFFFFFF.
    - Remainder = src1.
    - FSM goes straight to DONE.
  - Signed overflow (DIV/REM, src1==0x80000000, src2==0xFFFFFFFF):
    - Quotient = 0x80000000.
    - Remainder = 0.
    - FSM goes straight to DONE.
  - Otherwise the FSM goes to CALC with counter = 0.
- CALC (one step per cycle):
  - Multiply: shift-add on the 64-bit accumulator and unsigned magnitudes.
  - Divide: restoring step on the 33-bit partial remainder and 32-bit quotient.
  - When counter==31, go to DONE. Otherwise increment the counter.
- Sign fix and selection, on the CALC→DONE edge:
  - Product sign = s1^s2 for MULH; s1 only for MULHSU; none for MULHU.
  - MUL takes the low word and is sign-agnostic.
  - Quotient sign = s1^s2. Remainder takes the sign of the dividend.
  - MUL returns low 32 bits; MULH* return high 32 bits; DIV* return the quotient; REM* return the remainder.
- DONE:
  - `done`=1 for one cycle; `result` and `rd_index_out` are valid; the FSM always returns to IDLE.
  - `start` is ignored in DONE, because the same instruction is still in E.
  - `result` holds its value until the next DONE. `done` is 0 outside DONE.
- `stall` = (state==IDLE & start & !flush) | state==CALC. It is low in DONE so the pipeline advances.
- `flush` has priority over `start` and over FSM progression: any state → IDLE next edge, with no `done`.
- `rst` low mid-operation: IDLE next edge, all outputs 0.

## Timing
- Normal op, `start` high in cycle 0:
  - `stall` high cycles 0–32 (33 cycles).
  - `done` high in cycle 33.
  - Next instruction reaches E in cycle 34.
- Special case (divide by zero, overflow): `stall` high in cycle 0 only, `done` in cycle 1.
- Back-to-back M-ops: the second op's `start` is first honoured in the IDLE cycle after DONE.
- `stall` is combinational from `start`/`flush`/state. `done`, `result` and `rd_index_out` are registered.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - MUL/MULH/MULHSU/MULHU use a combinational 33x33 signed multiplier.
  - The FSM goes IDLE→DONE: `stall` 1 cycle, `done` in cycle 1.
  - Divides are unchanged.
- Undefined: all multiplies use the 32-step iteration and timing above.

## Structure
- Package `muldiv_pkg`:
  - func3 constants `F3_MUL`…`F3_REMU`.
  - State encoding IDLE/CALC/DONE.
  - `DIV0_Q`=0xFFFFFFFF, `OVF_Q`=0x80000000.
  - `MD_ITER`=32.
- One sub-module, `muldiv_step`: combinational single-iteration datapath (shift-add and restore-subtract).
- The top level owns the FSM, counter, operand latching and sign fix.

## Test plan
- MUL 7 × 0xFFFFFFFD → `stall` 33 cycles; `done` in cycle 33; `result`=0xFFFFFFEB; `rd_index_out`=latched rd.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULH same operands → 0x00000000. MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFFFFFF with 1 stall cycle. REM 5/0 → 5. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. REM same operands → 0.
- `flush` in cycle 10 of CALC → IDLE next edge; `stall` low; no `done`; `result` keeps its previous value. A new `start` then completes normally.
- `rst` low in cycle 15 of CALC → all outputs 0, IDLE. `start` held high through DONE → exactly one `done` pulse.
